// File: rtl/xung_do_tan_so.sv
// xung_do_tan_so -- period / high-time meter for a slow pulse train.
//
// Measures the signal sig_in against the fast reference clock clki and
// reports, once per period of sig_in:
//   - the period in clki cycles,
//   - the high time in clki cycles,
//   - a lock flag, raised once LOCK_N consecutive periods equal exp_div.
// This block sits at the checking end of the pulse-generator path. It
// recovers the divide ratio and the duty cycle from the divided signal.
//
// Ports:
//   clki      in   1      reference clock; all logic runs on its rising edge
//   rst       in   1      asynchronous, active-high reset
//   sig_in    in   1      measured pulse train, asynchronous to clki
//   exp_div   in   CNT_W  expected period in clki cycles; 0 disables lock checking
//   period_o  out  CNT_W  last measured period
//   high_o    out  CNT_W  last measured high time
//   valid_o   out  1      one-cycle strobe; period_o and high_o update with it
//   locked    out  1      LOCK_N consecutive periods have matched exp_div
//   timeout_o out  1      sticky no-edge flag; cleared by the next valid measurement
module xung_do_tan_so #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535,
    parameter int LOCK_N  = 4
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_div,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             locked,
    output logic             timeout_o
);

    localparam int               MW        = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_N);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic {
        WAIT_FIRST,
        MEAS
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_lat_q, high_lat_d;
    logic [MW-1:0]    match_q, match_d;
    logic [MW-1:0]    match_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             rise, fall;

    // The two-flop synchronizer and the extra delay flop add a fixed latency.
    // Because that latency is constant, the intervals between edges are
    // measured without error.
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign locked    = locked_q;
    assign timeout_o = timeout_q;

    // State register for the whole block.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_FIRST;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            high_lat_q <= '0;
            match_q    <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            high_lat_q <= high_lat_d;
            match_q    <= match_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: synchronizer, high-time counter, period counter,
    // measurement FSM and lock tracking.
    always_comb begin
        state_d    = state_q;
        s1_d       = sig_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        cnt_d      = cnt_q;
        hcnt_d     = hcnt_q;
        high_lat_d = high_lat_q;
        match_d    = match_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;

        // The match count saturates at LOCK_N, so locked holds while the
        // stream keeps matching.
        match_inc = (match_q == LOCK_V) ? match_q : match_q + 1'b1;

        // The high time starts at 1 in the rise cycle and counts every later
        // high cycle, saturating at all-ones. It is latched on the falling
        // edge, so it is ready for the next rise.
        if (rise) begin
            hcnt_d = ONE;
        end else if (s2_q && (hcnt_q != '1)) begin
            hcnt_d = hcnt_q + ONE;
        end
        if (fall) begin
            high_lat_d = hcnt_q;
        end

        unique case (state_q)
            WAIT_FIRST: begin
                // The first edge only arms the meter. No measurement exists yet.
                if (rise) begin
                    cnt_d   = ONE;
                    state_d = MEAS;
                end
            end
            MEAS: begin
                // A rise on the timeout cycle still counts as a normal
                // measurement.
                if (rise) begin
                    period_d  = cnt_q;
                    high_d    = high_lat_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = ONE;
                    if ((exp_div != '0) && (cnt_q == exp_div)) begin
                        match_d  = match_inc;
                        locked_d = (match_inc == LOCK_V);
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT_V) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    cnt_d     = '0;
                    state_d   = WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

endmodule

// File: doc/xung_do_tan_so.md
Name: xung_do_tan_so

Overview:
- Measures a slow pulse/clock train, such as the divider output `clko`, against the fast reference clock `clki`.
- Each period it reports:
  - the period in `clki` cycles,
  - the high time in `clki` cycles,
  - a lock flag, set when the measured period matches an expected division ratio.
- It is the checking end of the pulse-generator path: the generator divides `clki` down, and this block recovers the divide ratio and duty from the divided signal.

Parameters:
- CNT_W, 16, width of period/high counters and outputs.
- TIMEOUT, 65535, number of `clki` cycles without a rising edge before timeout; must be ≤ 2^CNT_W−1.
- LOCK_N, 4, number of consecutive matching periods required to assert `locked`.

Ports:
- clki  in  1  reference clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  1  measured pulse train; asynchronous to the block.
- exp_div  in  CNT_W  expected period in `clki` cycles; 0 disables lock checking.
- period_o  out  CNT_W  last measured period.
- high_o  out  CNT_W  last measured high time.
- valid_o  out  1  one-cycle strobe; `period_o` and `high_o` are updated in the same cycle.
- locked  out  1  period matched `exp_div` on LOCK_N consecutive measurements.
- timeout_o  out  1  sticky no-edge flag; cleared by the next valid measurement or by reset.

Behaviour:
- Synchronizer:
  - `sig_in` passes through two flops s1→s2, then one delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - The synchronizer delay is constant, so intervals between edges are preserved exactly.
- Reset (async, rst=1):
  - s1, s2, s3 = 0.
  - cnt = 0, hcnt = 0, high_lat = 0, match_cnt = 0.
  - period_o = 0, high_o = 0, valid_o = 0, locked = 0, timeout_o = 0.
  - state = WAIT_FIRST.
  - Reset mid-measurement discards the partial period with no valid strobe.
- States:
  - WAIT_FIRST: ignore everything until rise.
    - On rise: cnt ← 1, hcnt ← 1, go to MEAS.
    - No `valid_o` from the first edge; it only arms the block.
  - MEAS:
    - On rise: period_o ← cnt, high_o ← high_lat, valid_o = 1 next cycle, timeout_o ← 0, cnt ← 1, hcnt ← 1. Stay in MEAS.
    - Otherwise: cnt ← cnt + 1.
    - If cnt = TIMEOUT with no rise: timeout_o ← 1, locked ← 0, match_cnt ← 0, go to WAIT_FIRST. No valid strobe.
- Period timing: rises N cycles apart give period_o = N. valid_o is high exactly one cycle, in the cycle after the rise is detected.
- High time:
  - While s2 = 1 and it is not a rise cycle: hcnt ← hcnt + 1, saturating at all-ones.
  - On fall: high_lat ← hcnt.
  - A signal high for H cycles gives high_o = H at the next valid strobe.
  - A rise with no fall since the previous rise (stuck-high case) cannot occur in MEAS. A fall with no later rise ends in timeout.
- Lock, evaluated on each valid measurement:
  - If exp_div ≠ 0 and period = exp_div: match_cnt ← min(match_cnt + 1, LOCK_N); locked ← 1 when match_cnt reaches LOCK_N.
  - Else: match_cnt ← 0, locked ← 0 (deasserts in the same cycle valid_o rises).
  - Changing exp_div takes effect at the next measurement; locked is not cleared immediately.
- Simultaneous events: if rise and cnt = TIMEOUT occur in the same cycle, the rise wins (a normal measurement, no timeout).
- Minimum measurable period is 2 (pulse low ≥ 1 cycle and high ≥ 1 cycle after synchronization). Glitches shorter than one `clki` cycle may be lost; this is not checked.

Test Plan:
- Divider-by-10 source (5 high, 5 low), exp_div = 10 → from the 2nd rise on, valid_o every 10 cycles with period_o = 10, high_o = 5; locked = 1 on the 4th valid strobe, stays 1.
- Asymmetric source (3 high, 9 low), exp_div = 12 → period_o = 12, high_o = 3; locked after 4 strobes. Then change exp_div to 11 → locked drops at the next valid strobe; period_o stays 12.
- sig_in held at 0 after lock, TIMEOUT = 100 → timeout_o = 1 and locked = 0 exactly 100 cycles after the last rise was counted, with no valid_o. Restart the source → first rise arms only; the second rise gives valid_o, and timeout_o clears in that cycle.
- Assert rst for 1 cycle mid-period while locked → all outputs 0 immediately (asynchronously); no valid_o until two rises after rst is released.
- Single mismatched period (11 instead of 10) in a locked stream → locked = 0 at that strobe; relocks after 4 further periods of 10.
- exp_div = 0 with any source → period_o and high_o are correct, locked stays 0 throughout.
